// File: rtl/irq_controller_n.sv
// Multi-line interrupt controller: synchronised edge/level lines, arbitration, one-cycle take pulse.
// Optional per-line priority arbitration when IRQ_CTRL_PRIORITY_EN is defined.
module irq_controller_n #(
    parameter int unsigned IRQ_COUNT   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CODE_BASE   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IRQ_COUNT-1:0] irq,
    input  logic                 globalIE,
    input  logic                 mret,
    input  logic                 regWE,
    input  logic [2:0]           regAddr,
    input  logic [31:0]          regWrData,
    output logic [31:0]          regRdData,
    output logic                 interrupt,
    output logic [30:0]          intCode
);

    localparam int unsigned IDX_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] INSERVICE = 1'b1;

    logic [IRQ_COUNT-1:0] sync_q [SYNC_STAGES];
    logic [IRQ_COUNT-1:0] sync_dly_q;
    logic [IRQ_COUNT-1:0] enable_q;
    logic [IRQ_COUNT-1:0] mode_q;
    logic [IRQ_COUNT-1:0] pend_q;
    logic [0:0]           state_q;

    logic [IRQ_COUNT-1:0] level;
    logic [IRQ_COUNT-1:0] rise;
    logic [IRQ_COUNT-1:0] pend_eff;
    logic [IRQ_COUNT-1:0] cand;
    logic [IRQ_COUNT-1:0] w1c;
    logic [IRQ_COUNT-1:0] take;
    logic [IRQ_COUNT-1:0] pend_nxt;
    logic [IDX_W-1:0]     win_idx;
    logic                 found;
    logic [0:0]           state_nxt;
    logic                 interrupt_nxt;
    logic [30:0]          int_code_nxt;
    logic [31:0]          rd_nxt;
    logic                 unused_bits;

`ifdef IRQ_CTRL_PRIORITY_EN
    logic [3:0] prio_q [IRQ_COUNT];
    logic [3:0] best;
`endif

    assign unused_bits = ^regWrData;

    // Input synchroniser chain plus a delayed copy of the last stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
            sync_dly_q <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level    = sync_q[SYNC_STAGES-1];
    assign rise     = level & ~sync_dly_q;
    assign pend_eff = (pend_q & mode_q) | (level & ~mode_q);
    assign cand     = pend_eff & enable_q;
    assign w1c      = (regWE && regAddr == 3'd2) ? regWrData[IRQ_COUNT-1:0] : '0;
    // Set beats clear; level-mode lines never latch
    assign pend_nxt = ((pend_q & ~(take | w1c)) | rise) & mode_q;

    // Winner selection
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
`ifdef IRQ_CTRL_PRIORITY_EN
        best = 4'd0;
        for (int i = 0; i < int'(IRQ_COUNT); i++) begin
            if (cand[i] && prio_q[i] > best) begin
                best    = prio_q[i];
                win_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
`else
        for (int i = int'(IRQ_COUNT) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_nxt     = state_q;
        interrupt_nxt = 1'b0;
        int_code_nxt  = intCode;
        take          = '0;
        case (state_q)
            IDLE: begin
                if (globalIE && found) begin
                    interrupt_nxt = 1'b1;
                    int_code_nxt  = 31'(CODE_BASE) + 31'(win_idx);
                    take          = IRQ_COUNT'(1) << win_idx;
                    state_nxt     = INSERVICE;
                end
            end
            INSERVICE: begin
                if (mret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            interrupt <= 1'b0;
            intCode   <= '0;
        end else begin
            state_q   <= state_nxt;
            interrupt <= interrupt_nxt;
            intCode   <= int_code_nxt;
        end
    end

    // Register read mux
    always_comb begin
        rd_nxt = '0;
        case (regAddr)
            3'd0: rd_nxt = 32'(enable_q);
            3'd1: rd_nxt = 32'(mode_q);
            3'd2: rd_nxt = 32'(pend_eff);
            3'd3: rd_nxt = {1'b0, intCode[29:0], state_q == INSERVICE};
            default: begin
`ifdef IRQ_CTRL_PRIORITY_EN
                for (int i = 0; i < int'(IRQ_COUNT); i++) begin
                    if (regAddr == 3'(4 + i / 4)) rd_nxt[4*(i%4) +: 4] = prio_q[i];
                end
`else
                rd_nxt = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= '0;
            mode_q    <= '1;
            pend_q    <= '0;
            regRdData <= '0;
        end else begin
            pend_q    <= pend_nxt;
            regRdData <= rd_nxt;
            if (regWE && regAddr == 3'd0) enable_q <= regWrData[IRQ_COUNT-1:0];
            if (regWE && regAddr == 3'd1) mode_q   <= regWrData[IRQ_COUNT-1:0];
        end
    end

`ifdef IRQ_CTRL_PRIORITY_EN
    // Priority fields, four lines per word; zero masks the line
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(IRQ_COUNT); i++) prio_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < int'(IRQ_COUNT); i++) begin
                if (regWE && regAddr == 3'(4 + i / 4)) prio_q[i] <= regWrData[4*(i%4) +: 4];
            end
        end
    end
`endif

endmodule

// File: tb/tb_irq_controller_n.sv
// Directed bench for irq_controller_n: register table plus hand-written interrupt sequences.
module tb_irq_controller_n;

    localparam int unsigned N  = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned CB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq;
    logic          global_ie;
    logic          mret;
    logic          reg_we;
    logic [2:0]    reg_addr;
    logic [31:0]   reg_wr_data;
    logic [31:0]   reg_rd_data;
    logic          interrupt;
    logic [30:0]   int_code;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    irq_controller_n #(.IRQ_COUNT(N), .SYNC_STAGES(SS), .CODE_BASE(CB)) dut (
        .clk(clk), .reset(reset), .irq(irq), .globalIE(global_ie), .mret(mret),
        .regWE(reg_we), .regAddr(reg_addr), .regWrData(reg_wr_data),
        .regRdData(reg_rd_data), .interrupt(interrupt), .intCode(int_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wr_data = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        reg_addr = a;
        tick();
        v = reg_rd_data;
    endtask

    task automatic init_prio();
`ifdef IRQ_CTRL_PRIORITY_EN
        wr(3'd4, 32'h1111);
        wr(3'd5, 32'h1111);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1; irq = '0; global_ie = 1'b0; mret = 1'b0;
        reg_we = 1'b0; reg_addr = '0; reg_wr_data = '0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic wait_int(input int budget, output int n, output logic ok);
        ok = 1'b0; n = 0;
        while (n < budget && !ok) begin
            tick();
            n++;
            if (interrupt) ok = 1'b1;
        end
    endtask

    task automatic no_int(input int cycles, input string name);
        int cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (interrupt) cnt++;
        end
        check(name, 32'(cnt), 32'd0);
    endtask

    initial begin
        vec_t        tbl[13];
        logic [31:0] v;
        int          n;
        logic        ok;

        tbl[0]  = '{1'b0, 3'd0, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 3'd1, 32'h0,         32'hFF};
        tbl[2]  = '{1'b0, 3'd2, 32'h0,         32'h0};
        tbl[3]  = '{1'b0, 3'd3, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, 3'd0, 32'hA5,        32'hA5};
        tbl[5]  = '{1'b1, 3'd0, 32'hFFFF_FF5A, 32'h5A};
        tbl[6]  = '{1'b1, 3'd1, 32'h0F,        32'h0F};
        tbl[7]  = '{1'b1, 3'd1, 32'hFF,        32'hFF};
        tbl[8]  = '{1'b1, 3'd3, 32'hFFFF,      32'h0};
        tbl[9]  = '{1'b1, 3'd2, 32'hFF,        32'h0};
`ifdef IRQ_CTRL_PRIORITY_EN
        tbl[10] = '{1'b1, 3'd4, 32'h1234,      32'h1234};
`else
        tbl[10] = '{1'b1, 3'd4, 32'h1234,      32'h0};
`endif
        tbl[11] = '{1'b1, 3'd7, 32'hFFFF,      32'h0};
        tbl[12] = '{1'b1, 3'd0, 32'h0,         32'h0};

        do_reset();
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_code", 32'(int_code), 32'd0);
        check("rst_rddata", reg_rd_data, 32'd0);

        foreach (tbl[i]) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, v);
            check($sformatf("reg_vec%0d", i), v, tbl[i].exp);
        end
        init_prio();

        // Single edge pulse on line 0: latency, one-cycle pulse, status
        wr(3'd0, 32'h01);
        global_ie = 1'b1;
        irq = 8'h01; n = 0; ok = 1'b0;
        while (n < 20 && !ok) begin
            tick();
            n++;
            if (n == 1) irq = '0;
            if (interrupt) ok = 1'b1;
        end
        check("t1_seen", 32'(ok), 32'd1);
        check("t1_latency", 32'(n), 32'(SS + 2));
        check("t1_code", 32'(int_code), 32'd16);
        tick();
        check("t1_one_cycle", 32'(interrupt), 32'd0);
        rd(3'd2, v); check("t1_pending", v, 32'h0);
        rd(3'd3, v); check("t1_status", v, 32'd33);
        pulse_mret();
        rd(3'd3, v); check("t1_status_idle", v, 32'd32);
        no_int(5, "t1_quiet");

        // Lines 3 and 5 together: lowest first, next take right after IDLE
        wr(3'd0, 32'hFF);
        irq = 8'h28;
        wait_int(20, n, ok);
        check("t2_seen", 32'(ok), 32'd1);
        check("t2_code_a", 32'(int_code), 32'd19);
        no_int(6, "t2_no_nest");
        rd(3'd2, v); check("t2_pending", v, 32'h20);
        pulse_mret();
        tick();
        check("t2_retake", 32'(interrupt), 32'd1);
        check("t2_code_b", 32'(int_code), 32'd21);
        irq = '0;
        pulse_mret();
        no_int(8, "t2_quiet");

        // Level mode on line 2
        wr(3'd1, 32'hFB);
        irq = 8'h04;
        wait_int(20, n, ok);
        check("t3_seen", 32'(ok), 32'd1);
        check("t3_code", 32'(int_code), 32'd18);
        for (int k = 0; k < 2; k++) begin
            pulse_mret();
            tick();
            check($sformatf("t3_retake%0d", k), 32'(interrupt), 32'd1);
            check($sformatf("t3_recode%0d", k), 32'(int_code), 32'd18);
        end
        irq = '0;
        repeat (6) tick();
        rd(3'd2, v); check("t3_pending_low", v, 32'h0);
        pulse_mret();
        no_int(10, "t3_no_take");
        wr(3'd1, 32'hFF);

        // Edge pending held with globalIE low, then cleared by W1C
        global_ie = 1'b0;
        irq = 8'h02;
        tick();
        irq = '0;
        no_int(6, "t4_masked");
        rd(3'd2, v); check("t4_pending", v, 32'h02);
        wr(3'd2, 32'h02);
        rd(3'd2, v); check("t4_w1c", v, 32'h0);
        global_ie = 1'b1;
        no_int(10, "t4_no_take");

        // Reset while in service with pending lines
        irq = 8'h01;
        tick();
        irq = '0;
        wait_int(20, n, ok);
        check("t5_seen", 32'(ok), 32'd1);
        check("t5_code", 32'(int_code), 32'd16);
        irq = 8'h0C;
        tick();
        irq = '0;
        repeat (5) tick();
        rd(3'd2, v); check("t5_pending", v, 32'h0C);
        rd(3'd3, v); check("t5_status", v, 32'd33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_interrupt", 32'(interrupt), 32'd0);
        check("t5_rst_code", 32'(int_code), 32'd0);
        rd(3'd3, v); check("t5_rst_status", v, 32'd0);
        rd(3'd2, v); check("t5_rst_pending", v, 32'h0);

`ifdef IRQ_CTRL_PRIORITY_EN
        // Priority arbitration and masking by priority 0
        do_reset();
        wr(3'd0, 32'hFF);
        wr(3'd4, 32'h1);
        wr(3'd5, 32'h900);
        irq = 8'h41;
        tick();
        irq = '0;
        repeat (6) tick();
        global_ie = 1'b1;
        wait_int(20, n, ok);
        check("t6_seen", 32'(ok), 32'd1);
        check("t6_code_hi", 32'(int_code), 32'd22);
        irq = 8'h40;
        tick();
        irq = '0;
        wr(3'd5, 32'h0);
        repeat (5) tick();
        pulse_mret();
        tick();
        check("t6_retake", 32'(interrupt), 32'd1);
        check("t6_code_masked", 32'(int_code), 32'd16);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
